// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters and execute-stage redirect logic.
// Optional BP_BYPASS_EN forwards a same-cycle table update to the fetch lookup.
module branch_predictor #(
    parameter int IADDR_SPACE_BITS = 16,
    parameter int BTB_ENTRIES      = 8,
    parameter int CNT_BITS         = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [IADDR_SPACE_BITS-1:1] i_fetch_pc,
    output logic                        o_pred_taken,
    output logic [IADDR_SPACE_BITS-1:1] o_pred_target,
    input  logic                        i_ex_valid,
    input  logic                        i_ex_jal_jalr,
    input  logic                        i_ex_branch,
    input  logic                        i_ex_cmp,
    input  logic                        i_ex_pred,
    input  logic [IADDR_SPACE_BITS-1:1] i_ex_pred_target,
    input  logic [IADDR_SPACE_BITS-1:1] i_ex_pc,
    input  logic [IADDR_SPACE_BITS-1:1] i_ex_pc_next,
    input  logic [IADDR_SPACE_BITS-1:1] i_ex_pc_target,
    output logic                        o_pc_select,
    output logic [IADDR_SPACE_BITS-1:1] o_pc_target,
    output logic [15:0]                 o_mispred_cnt
);

    localparam int IA       = IADDR_SPACE_BITS;
    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = IA - 1 - IDX_BITS;

    localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX     = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_ONE << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_ONE;

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [BTB_ENTRIES];
    logic [IA-1:1]       target_q [BTB_ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [BTB_ENTRIES];
    logic [15:0]         mispredCnt_q, mispredCnt_d;

    logic [IDX_BITS-1:0] fIdx, eIdx;
    logic [TAG_BITS-1:0] fTag, eTag;

    logic                wrEn_d;
    logic                wrValid_d;
    logic [TAG_BITS-1:0] wrTag_d;
    logic [IA-1:1]       wrTarget_d;
    logic [CNT_BITS-1:0] wrCnt_d;

    logic                rdValid;
    logic [TAG_BITS-1:0] rdTag;
    logic [IA-1:1]       rdTarget;
    logic [CNT_BITS-1:0] rdCnt;
    logic                rdHit;
    logic                bypassHit;

    logic exAct, exCtrl, exHit;

    assign fIdx   = i_fetch_pc[IDX_BITS:1];
    assign fTag   = i_fetch_pc[IA-1:IDX_BITS+1];
    assign eIdx   = i_ex_pc[IDX_BITS:1];
    assign eTag   = i_ex_pc[IA-1:IDX_BITS+1];
    assign exAct  = i_ex_jal_jalr | (i_ex_branch & i_ex_cmp);
    assign exCtrl = i_ex_jal_jalr | i_ex_branch;
    assign exHit  = valid_q[eIdx] && (tag_q[eIdx] == eTag);

    always_comb begin
        o_pc_select = 1'b0;
        o_pc_target = i_ex_pc_next;
        if (i_ex_valid) begin
            if (exAct && (!i_ex_pred || (i_ex_pred_target != i_ex_pc_target))) begin
                o_pc_select = 1'b1;
                o_pc_target = i_ex_pc_target;
            end else if (!exAct && i_ex_pred) begin
                o_pc_select = 1'b1;
            end
        end
    end

    // Post-update image of the entry at the execute PC's index.
    always_comb begin
        wrEn_d     = 1'b0;
        wrValid_d  = valid_q[eIdx];
        wrTag_d    = tag_q[eIdx];
        wrTarget_d = target_q[eIdx];
        wrCnt_d    = cnt_q[eIdx];
        if (i_ex_valid && exCtrl) begin
            if (exHit && exAct) begin
                wrEn_d     = 1'b1;
                wrTarget_d = i_ex_pc_target;
                if (cnt_q[eIdx] != CNT_MAX) begin
                    wrCnt_d = cnt_q[eIdx] + CNT_ONE;
                end
            end else if (exHit) begin
                wrEn_d = 1'b1;
                if (cnt_q[eIdx] != '0) begin
                    wrCnt_d = cnt_q[eIdx] - CNT_ONE;
                end
            end else if (exAct) begin
                wrEn_d     = 1'b1;
                wrValid_d  = 1'b1;
                wrTag_d    = eTag;
                wrTarget_d = i_ex_pc_target;
                wrCnt_d    = CNT_WEAK_T;
            end
        end else if (i_ex_valid && i_ex_pred) begin
            wrEn_d    = 1'b1;
            wrValid_d = 1'b0;
        end
    end

`ifdef BP_BYPASS_EN
    assign bypassHit = wrEn_d && !i_reset && (eIdx == fIdx);
`else
    assign bypassHit = 1'b0;
`endif

    always_comb begin
        rdValid  = valid_q[fIdx];
        rdTag    = tag_q[fIdx];
        rdTarget = target_q[fIdx];
        rdCnt    = cnt_q[fIdx];
        if (bypassHit) begin
            rdValid  = wrValid_d;
            rdTag    = wrTag_d;
            rdTarget = wrTarget_d;
            rdCnt    = wrCnt_d;
        end
    end

    assign rdHit         = rdValid && (rdTag == fTag);
    assign o_pred_taken  = rdHit && rdCnt[CNT_BITS-1];
    assign o_pred_target = rdHit ? rdTarget : '0;

    assign mispredCnt_d  = (o_pc_select && (mispredCnt_q != 16'hFFFF)) ?
                           mispredCnt_q + 16'd1 : mispredCnt_q;
    assign o_mispred_cnt = mispredCnt_q;

    // Reset takes priority over any update presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
            mispredCnt_q <= '0;
        end else begin
            if (wrEn_d) begin
                valid_q[eIdx]  <= wrValid_d;
                tag_q[eIdx]    <= wrTag_d;
                target_q[eIdx] <= wrTarget_d;
                cnt_q[eIdx]    <= wrCnt_d;
            end
            mispredCnt_q <= mispredCnt_d;
        end
    end

endmodule
